// File: rtl/weight_loader.sv
// Weight FIFO loader: on start, streams FIFO_STAGES consecutive rows from a
// synchronous weight memory into the weight FIFO; when idle, forwards arrayShift.
module weight_loader #(
    parameter int DATA_WIDTH  = 8,
    parameter int FIFO_INPUTS = 4,
    parameter int FIFO_WIDTH  = DATA_WIDTH * FIFO_INPUTS,
    parameter int FIFO_STAGES = 4,
    parameter int ADDR_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] baseAddr,
    input  logic                  arrayShift,
    output logic                  memRdEn,
    output logic [ADDR_WIDTH-1:0] memAddr,
    input  logic [FIFO_WIDTH-1:0] memData,
    output logic                  fifoEn,
    output logic [FIFO_WIDTH-1:0] fifoData,
    output logic                  busy,
    output logic                  done
);

    localparam int CNT_W = (FIFO_STAGES > 1) ? $clog2(FIFO_STAGES) : 1;
    localparam logic [CNT_W-1:0] LAST_ISSUE = CNT_W'(FIFO_STAGES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                  state_r;
    logic [CNT_W-1:0]        cnt_r;
    logic [ADDR_WIDTH-1:0]   base_r;
    logic [ADDR_WIDTH-1:0]   mem_addr_r;
    logic                    mem_rd_en_r;
    logic                    rd_valid_r;
    logic                    busy_r;
    logic                    done_r;
    logic                    fifo_en_s;
    logic [FIFO_WIDTH-1:0]   fifo_data_s;

    // Load sequencer: issues one read per LOAD cycle, then drains and pulses done.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            base_r      <= {ADDR_WIDTH{1'b0}};
            mem_addr_r  <= {ADDR_WIDTH{1'b0}};
            mem_rd_en_r <= 1'b0;
            rd_valid_r  <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            rd_valid_r <= mem_rd_en_r;
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        base_r      <= baseAddr;
                        cnt_r       <= {CNT_W{1'b0}};
                        mem_addr_r  <= baseAddr;
                        mem_rd_en_r <= 1'b1;
                        busy_r      <= 1'b1;
                        state_r     <= LOAD;
                    end else begin
                        mem_rd_en_r <= 1'b0;
                        busy_r      <= 1'b0;
                    end
                end
                LOAD: begin
                    if (cnt_r == LAST_ISSUE) begin
                        mem_rd_en_r <= 1'b0;
                        mem_addr_r  <= {ADDR_WIDTH{1'b0}};
                        state_r     <= DRAIN;
                    end else begin
                        // Address add wraps modulo 2^ADDR_WIDTH by truncation.
                        cnt_r      <= cnt_r + CNT_W'(1);
                        mem_addr_r <= base_r + ADDR_WIDTH'(cnt_r + CNT_W'(1));
                    end
                end
                DRAIN: begin
                    done_r  <= 1'b1;
                    state_r <= DONE;
                end
                DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r     <= IDLE;
                    mem_rd_en_r <= 1'b0;
                    busy_r      <= 1'b0;
                    done_r      <= 1'b0;
                end
            endcase
        end
    end

    // FIFO drive: read data pushes when valid, else idle pass-through of arrayShift.
    always_comb begin
        fifo_en_s   = 1'b0;
        fifo_data_s = {FIFO_WIDTH{1'b0}};
        if (rd_valid_r) begin
            fifo_en_s   = 1'b1;
            fifo_data_s = memData;
        end else if ((state_r == IDLE) && reset) begin
            fifo_en_s = arrayShift;
        end else begin
            fifo_en_s = 1'b0;
        end
    end

    assign memRdEn  = mem_rd_en_r;
    assign memAddr  = mem_addr_r;
    assign fifoEn   = fifo_en_s;
    assign fifoData = fifo_data_s;
    assign busy     = busy_r;
    assign done     = done_r;

endmodule

// File: tb/tb_weight_loader.sv
// Directed self-checking bench for weight_loader with a behavioural memory and FIFO.
module tb_weight_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  baseAddr = 8'h00;
    logic        arrayShift = 1'b0;
    logic        memRdEn;
    logic [7:0]  memAddr;
    logic [31:0] memData = 32'h0;
    logic        fifoEn;
    logic [31:0] fifoData;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] mem [0:255];
    logic [31:0] fq  [0:3];

    logic        c_rd   [1:8];
    logic [7:0]  c_addr [1:8];
    logic        c_en   [1:8];
    logic [31:0] c_data [1:8];
    logic        c_busy [1:8];
    logic        c_done [1:8];

    weight_loader dut (
        .clk(clk), .reset(reset), .start(start), .baseAddr(baseAddr),
        .arrayShift(arrayShift), .memRdEn(memRdEn), .memAddr(memAddr),
        .memData(memData), .fifoEn(fifoEn), .fifoData(fifoData),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (memRdEn) memData <= mem[memAddr];
    end

    always @(posedge clk) begin
        if (fifoEn) begin
            fq[3] <= fq[2];
            fq[2] <= fq[1];
            fq[1] <= fq[0];
            fq[0] <= fifoData;
        end
    end

    task automatic capture(input logic [7:0] base, input int restart_cyc,
                           input logic [7:0] restart_base, input bit shift_load,
                           input bit chained, input int ncyc);
        if (!chained) begin
            @(negedge clk);
            baseAddr = base;
            start    = 1'b1;
        end
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            start = (k == restart_cyc);
            if (k == restart_cyc) baseAddr = restart_base;
            arrayShift = shift_load && (k <= 5);
            #1;
            c_rd[k]   = memRdEn;
            c_addr[k] = memAddr;
            c_en[k]   = fifoEn;
            c_data[k] = fifoData;
            c_busy[k] = busy;
            c_done[k] = done;
        end
        arrayShift = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({memRdEn, fifoEn, busy, done} !== 4'b0000 || memAddr !== 8'h00 || fifoData !== 32'h0) begin
            n_err++;
            $display("FAIL reset_state: got rd=%b en=%b busy=%b done=%b addr=%h data=%h, want all 0",
                     memRdEn, fifoEn, busy, done, memAddr, fifoData);
        end
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({memRdEn, fifoEn, busy, done} !== 4'b0000) begin
            n_err++;
            $display("FAIL idle_after_reset: got rd=%b en=%b busy=%b done=%b, want 0000",
                     memRdEn, fifoEn, busy, done);
        end
    endtask

    task automatic test_basic();
        logic [31:0] rows [0:3];
        rows[0] = 32'h01010101; rows[1] = 32'h02020202;
        rows[2] = 32'h03030303; rows[3] = 32'h04040404;
        capture(8'h10, 0, 8'h00, 1'b0, 1'b0, 8);
        for (int k = 1; k <= 8; k++) begin
            n_cmp++;
            if (c_rd[k] !== (k >= 1 && k <= 4)) begin
                n_err++;
                $display("FAIL basic_rden c%0d: got %b want %b", k, c_rd[k], (k <= 4));
            end
            if (k <= 4) begin
                n_cmp++;
                if (c_addr[k] !== 8'h10 + 8'(k - 1)) begin
                    n_err++;
                    $display("FAIL basic_addr c%0d: got %h want %h", k, c_addr[k], 8'h10 + 8'(k - 1));
                end
            end
            n_cmp++;
            if (c_en[k] !== (k >= 2 && k <= 5)) begin
                n_err++;
                $display("FAIL basic_fifoen c%0d: got %b want %b", k, c_en[k], (k >= 2 && k <= 5));
            end
            n_cmp++;
            if (c_data[k] !== ((k >= 2 && k <= 5) ? rows[k - 2] : 32'h0)) begin
                n_err++;
                $display("FAIL basic_data c%0d: got %h want %h", k, c_data[k],
                         (k >= 2 && k <= 5) ? rows[k - 2] : 32'h0);
            end
            n_cmp++;
            if (c_busy[k] !== (k <= 6) || c_done[k] !== (k == 6)) begin
                n_err++;
                $display("FAIL basic_busy_done c%0d: got busy=%b done=%b want busy=%b done=%b",
                         k, c_busy[k], c_done[k], (k <= 6), (k == 6));
            end
        end
        n_cmp++;
        if (fq[3] !== 32'h01010101 || fq[0] !== 32'h04040404) begin
            n_err++;
            $display("FIFO_CHECK FAIL basic_fifo_contents: got out=%h in=%h want 01010101 04040404", fq[3], fq[0]);
        end
    endtask

    task automatic test_wrap();
        logic [7:0]  addrs [0:3];
        logic [31:0] rows  [0:3];
        addrs[0] = 8'hFE; addrs[1] = 8'hFF; addrs[2] = 8'h00; addrs[3] = 8'h01;
        rows[0] = 32'hFEFEFEFE; rows[1] = 32'hFFFFFFFF; rows[2] = 32'h00000000; rows[3] = 32'h01010101;
        capture(8'hFE, 0, 8'h00, 1'b0, 1'b0, 7);
        for (int k = 1; k <= 4; k++) begin
            n_cmp++;
            if (c_rd[k] !== 1'b1 || c_addr[k] !== addrs[k - 1]) begin
                n_err++;
                $display("FAIL wrap_addr c%0d: got rd=%b addr=%h want 1 %h", k, c_rd[k], c_addr[k], addrs[k - 1]);
            end
            n_cmp++;
            if (c_en[k + 1] !== 1'b1 || c_data[k + 1] !== rows[k - 1]) begin
                n_err++;
                $display("FAIL wrap_data c%0d: got en=%b data=%h want 1 %h", k + 1, c_en[k + 1], c_data[k + 1], rows[k - 1]);
            end
        end
    endtask

    task automatic test_start_busy();
        int pushes;
        int dones;
        capture(8'h20, 3, 8'h40, 1'b1, 1'b0, 8);
        pushes = 0;
        dones  = 0;
        for (int k = 1; k <= 8; k++) begin
            if (c_en[k] === 1'b1) pushes++;
            if (c_done[k] === 1'b1) dones++;
        end
        n_cmp++;
        if (pushes != 4) begin
            n_err++;
            $display("FAIL busy_push_count: got %0d want 4", pushes);
        end
        n_cmp++;
        if (dones != 1) begin
            n_err++;
            $display("FAIL busy_done_count: got %0d want 1", dones);
        end
        n_cmp++;
        if (c_addr[4] !== 8'h23 || c_en[1] !== 1'b0) begin
            n_err++;
            $display("FAIL busy_ignore: got addr4=%h en1=%b want 23 0", c_addr[4], c_en[1]);
        end
    endtask

    task automatic test_idle_pass();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            arrayShift = 1'b1;
            #1;
            n_cmp++;
            if (fifoEn !== 1'b1 || fifoData !== 32'h0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL idle_pass c%0d: got en=%b data=%h busy=%b want 1 0 0", k, fifoEn, fifoData, busy);
            end
        end
        @(negedge clk);
        arrayShift = 1'b0;
        #1;
        n_cmp++;
        if (fifoEn !== 1'b0) begin
            n_err++;
            $display("FAIL idle_pass_off: got en=%b want 0", fifoEn);
        end
        @(negedge clk);
        arrayShift = 1'b1;
        baseAddr   = 8'h10;
        start      = 1'b1;
        #1;
        n_cmp++;
        if (fifoEn !== 1'b1 || fifoData !== 32'h0) begin
            n_err++;
            $display("FAIL start_with_shift: got en=%b data=%h want 1 0", fifoEn, fifoData);
        end
        capture(8'h10, 0, 8'h00, 1'b0, 1'b1, 8);
        n_cmp++;
        if (c_addr[1] !== 8'h10 || c_rd[1] !== 1'b1 || c_done[6] !== 1'b1) begin
            n_err++;
            $display("FAIL start_with_shift_load: got rd1=%b addr1=%h done6=%b want 1 10 1", c_rd[1], c_addr[1], c_done[6]);
        end
    endtask

    task automatic test_back_to_back();
        capture(8'h10, 7, 8'h30, 1'b0, 1'b0, 7);
        n_cmp++;
        if (c_done[6] !== 1'b1 || c_busy[7] !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_first: got done6=%b busy7=%b want 1 0", c_done[6], c_busy[7]);
        end
        capture(8'h30, 0, 8'h00, 1'b0, 1'b1, 8);
        for (int k = 1; k <= 4; k++) begin
            n_cmp++;
            if (c_addr[k] !== 8'h30 + 8'(k - 1) || c_en[k + 1] !== 1'b1
                || c_data[k + 1] !== {4{8'h30 + 8'(k - 1)}}) begin
                n_err++;
                $display("FAIL b2b_second c%0d: got addr=%h en=%b data=%h want %h 1 %h", k, c_addr[k],
                         c_en[k + 1], c_data[k + 1], 8'h30 + 8'(k - 1), {4{8'h30 + 8'(k - 1)}});
            end
        end
        n_cmp++;
        if (c_done[6] !== 1'b1 || c_busy[6] !== 1'b1 || c_busy[7] !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_second_done: got done6=%b busy6=%b busy7=%b want 1 1 0", c_done[6], c_busy[6], c_busy[7]);
        end
    endtask

    task automatic test_reset_mid();
        int dones;
        int pushes;
        @(negedge clk);
        baseAddr = 8'h50;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({memRdEn, fifoEn, busy, done} !== 4'b0000 || memAddr !== 8'h00 || fifoData !== 32'h0) begin
            n_err++;
            $display("FAIL reset_mid_outputs: got rd=%b en=%b busy=%b done=%b addr=%h data=%h want all 0",
                     memRdEn, fifoEn, busy, done, memAddr, fifoData);
        end
        dones = 0;
        repeat (3) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        reset = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        n_cmp++;
        if (dones != 0) begin
            n_err++;
            $display("FAIL reset_mid_no_done: got %0d done pulses want 0", dones);
        end
        capture(8'h12, 0, 8'h00, 1'b0, 1'b0, 8);
        pushes = 0;
        for (int k = 1; k <= 8; k++) if (c_en[k] === 1'b1) pushes++;
        n_cmp++;
        if (c_addr[1] !== 8'h12 || c_addr[4] !== 8'h15 || pushes != 4 || c_done[6] !== 1'b1
            || c_data[5] !== 32'h15151515) begin
            n_err++;
            $display("FAIL reset_mid_reload: got addr1=%h addr4=%h pushes=%0d done6=%b data5=%h want 12 15 4 1 15151515",
                     c_addr[1], c_addr[4], pushes, c_done[6], c_data[5]);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = {4{8'(i)}};
        mem[8'h10] = 32'h01010101;
        mem[8'h11] = 32'h02020202;
        mem[8'h12] = 32'h03030303;
        mem[8'h13] = 32'h04040404;
        mem[8'h00] = 32'h00000000;
        for (int i = 0; i < 4; i++) fq[i] = 32'hDEADBEEF;
        test_reset();
        test_basic();
        test_wrap();
        test_start_busy();
        test_idle_pass();
        test_back_to_back();
        mem[8'h15] = 32'h15151515;
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
